// File: rtl/sap1_bcd_display.sv
// SAP-1 output display: a sequential double-dabble turns each OUT byte into three BCD
// digits, which are then time-multiplexed onto a shared active-high 7-segment bus.
module sap1_bcd_display #(
  parameter int SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  value_in,
  input  logic        value_valid,
  output logic        busy,
  output logic [11:0] bcd_out,
  output logic        bcd_valid,
  output logic [6:0]  seg_out,
  output logic [2:0]  digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [19:0] scratch, adj, shifted;
  logic [2:0]  cnt;
  logic        pending, start, fin;
  logic [7:0]  pend_val, start_val;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE:  if (value_valid || pending) begin start = 1'b1; state_nxt = SHIFT; end
      SHIFT: if (cnt == 3'd7) begin fin = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  // Fresh strobe beats a buffered value when both are present in IDLE.
  assign start_val = value_valid ? value_in : pend_val;
  assign busy      = (state == SHIFT);

  always_comb begin
    adj = scratch;
    for (int i = 2; i < 5; i++)
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
  end
  assign shifted = {adj[18:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch   <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      pending   <= 1'b0;
      pend_val  <= '0;
    end else begin
      bcd_valid <= 1'b0;
      if (start) begin
        scratch <= {12'b0, start_val};
        cnt     <= '0;
        pending <= 1'b0;
      end else if (state == SHIFT) begin
        scratch <= shifted;
        cnt     <= cnt + 3'd1;
        if (fin) begin
          bcd_out   <= shifted[19:8];
          bcd_valid <= 1'b1;
        end
        // One-deep buffer: the latest strobe during a conversion wins.
        if (value_valid) begin
          pending  <= 1'b1;
          pend_val <= value_in;
        end
      end
    end
  end

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic          wrap;

  assign wrap = (presc == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= wrap ? '0 : presc + PW'(1);
      if (wrap) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  assign digit_sel = 3'b001 << idx;

  logic [3:0] nib;
  logic       blank;

  always_comb begin
    nib   = bcd_out[3:0];
    blank = 1'b0;
    case (idx)
      2'd1: begin
        nib   = bcd_out[7:4];
        blank = (bcd_out[11:4] == 8'h00);
      end
      2'd2: begin
        nib   = bcd_out[11:8];
        blank = (bcd_out[11:8] == 4'h0);
      end
      default: ;
    endcase
  end

  always_comb begin
    seg_out = 7'h00;
    if (!blank)
      case (nib)
        4'd0: seg_out = 7'h3F;
        4'd1: seg_out = 7'h06;
        4'd2: seg_out = 7'h5B;
        4'd3: seg_out = 7'h4F;
        4'd4: seg_out = 7'h66;
        4'd5: seg_out = 7'h6D;
        4'd6: seg_out = 7'h7D;
        4'd7: seg_out = 7'h07;
        4'd8: seg_out = 7'h7F;
        4'd9: seg_out = 7'h6F;
        default: seg_out = 7'h00;
      endcase
  end

endmodule

// File: tb/tb_sap1_bcd_display.sv
// Directed bench for sap1_bcd_display: conversions are scoreboarded with their expected
// completion cycle, and the scanned display is checked digit by digit.
module tb_sap1_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  value_in;
  logic        value_valid;
  logic        busy;
  logic [11:0] bcd_out;
  logic        bcd_valid;
  logic [6:0]  seg_out;
  logic [2:0]  digit_sel;

  sap1_bcd_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .value_in(value_in), .value_valid(value_valid),
    .busy(busy), .bcd_out(bcd_out), .bcd_valid(bcd_valid),
    .seg_out(seg_out), .digit_sel(digit_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Advance one edge, sample #1 later, and retire any completed conversion.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (bcd_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 32'(bcd_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  endtask

  // lat < 0: the value is expected never to reach the display.
  task automatic strobe(input int v, input int lat);
    exp_t e;
    value_in    = 8'(v);
    value_valid = 1'b1;
    if (lat >= 0) begin
      e.bcd = to_bcd(v);
      e.cyc = cyc + 1 + lat;
      q.push_back(e);
    end
    tick();
    value_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2);
    logic [2:0] seen = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      case (digit_sel)
        3'b001: begin chk({tag, "_ones"}, 32'(seg_out), 32'(s0)); seen[0] = 1'b1; end
        3'b010: begin chk({tag, "_tens"}, 32'(seg_out), 32'(s1)); seen[1] = 1'b1; end
        3'b100: begin chk({tag, "_hund"}, 32'(seg_out), 32'(s2)); seen[2] = 1'b1; end
        default: chk({tag, "_onehot"}, 32'(digit_sel), 32'd1);
      endcase
    end
    chk({tag, "_all_digits"}, 32'(seen), 32'd7);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'd0);
    chk({tag, "_sel"}, 32'(digit_sel), 32'd1);
    chk({tag, "_seg"}, 32'(seg_out), 32'h3F);
  endtask

  initial begin
    rst_n       = 1'b0;
    value_in    = '0;
    value_valid = 1'b0;
    #3;
    chk_reset_state("por");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 255: full-range value, busy window and scan order
    strobe(255, 8);
    chk("busy_high", 32'(busy), 32'd1);
    drain(20);
    chk("busy_low", 32'(busy), 32'd0);
    scan_check("s255", 7'h6D, 7'h6D, 7'h5B);

    // 0: both upper digits blanked, ones still shows 0
    strobe(0, 8);
    drain(20);
    scan_check("s0", 7'h3F, 7'h00, 7'h00);

    // 105: an inner zero is not blanked
    strobe(105, 8);
    drain(20);
    scan_check("s105", 7'h6D, 7'h3F, 7'h06);

    // 7 then 42 and 99 while busy: 42 is overwritten, 99 follows 7 after 9 cycles
    strobe(7, 8);
    tick();
    tick();
    strobe(42, -1);
    tick();
    strobe(99, 12);
    drain(30);
    chk("pend_final", 32'(bcd_out), 32'h099);
    scan_check("s99", 7'h6F, 7'h6F, 7'h00);

    // Reset in the middle of a conversion of 200
    strobe(200, -1);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_reset_state("rst_hold");
    end
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("post_rst_bcd", 32'(bcd_out), 32'd0);
    strobe(13, 8);
    drain(20);
    chk("fresh_13", 32'(bcd_out), 32'h013);
    scan_check("s13", 7'h4F, 7'h06, 7'h00);

    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sap1_bcd_display.md
# sap1_bcd_display

Output display stage for the SAP-1 CPU. It sits downstream of the output register and converts each new 8-bit OUT value into three BCD digits using a sequential double-dabble, one shift per clock. It then time-multiplexes the digits onto a shared active-high 7-segment bus with one-hot digit selects. The display always shows the last completed conversion, never intermediate values.

## Interface
- SCAN_DIV, default 1000: clock cycles each digit stays selected; legal range ≥1.

- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- value_in  in  8  unsigned value from output register
- value_valid  in  1  one-cycle strobe, asserted the cycle after the output register loads
- busy  out  1  conversion in progress (state SHIFT)
- bcd_out  out  12  {hundreds, tens, ones} of the last completed conversion
- bcd_valid  out  1  one-cycle pulse when bcd_out updates
- seg_out  out  7  segments {g,f,e,d,c,b,a}, active-high
- digit_sel  out  3  one-hot digit enable; bit0 = ones, bit1 = tens, bit2 = hundreds

## Operation
- FSM has two states: IDLE and SHIFT.
- Start condition in IDLE: value_valid = 1, or pending = 1.
  - On start, scratch[19:0] ← {12'b0, v} and cnt ← 0; go to SHIFT.
  - v is value_in if value_valid = 1 (clears pending); otherwise pend_val (clears pending).
- SHIFT, one iteration per clock:
  - Add 3 to each nibble scratch[11:8], [15:12], [19:16] that is ≥5 (the fixup is applied to all three nibbles within the same iteration).
  - Shift the whole 20-bit scratch left by 1; cnt ← cnt + 1.
  - On the iteration where cnt = 7 (8th): bcd_out ← result[19:8], bcd_valid ← 1, go to IDLE.
- value_valid while busy: pend_val ← value_in, pending ← 1. The buffer is one-deep; the latest value overwrites any earlier pending value. The running conversion is not disturbed.
- Leading-zero blanking:
  - Hundreds digit is blank if hundreds = 0.
  - Tens digit is blank if hundreds = 0 and tens = 0.
  - Ones digit is never blanked.
  - A blank digit drives seg_out = 0; digit_sel is still driven.
- Segment codes, digits 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- BCD nibbles above 9 cannot occur.
- Scan:
  - Prescaler counts 0 to SCAN_DIV−1 and wraps.
  - On wrap, digit index advances 0→1→2→0.
  - digit_sel = 1 << index.
  - seg_out is combinational from the registered index and bcd_out.

## Timing
- Reset values (asynchronous, held while rst_n = 0):
  - State IDLE; busy 0; bcd_out 000; bcd_valid 0; pending 0; pend_val 00; prescaler 0; index 0.
  - digit_sel 001; seg_out 3F.
- Latency:
  - value_valid sampled at edge N.
  - SHIFT iterations occur at edges N+1 through N+8.
  - bcd_out and bcd_valid are updated at edge N+8; bcd_valid drops at N+9.
  - busy is high from after edge N until edge N+8.
- A pending value starts at the first edge in IDLE (N+9), so back-to-back conversion throughput is one per 9 cycles.
- value_valid in the same cycle as the final SHIFT iteration goes to pending.
- value_valid while IDLE with pending set: value_in wins and pend_val is dropped.
- Reset mid-SHIFT aborts the conversion. bcd_out returns to 000, and the old value is not restored after reset.
- Display bus changes only at index advance, or at the edge that updates bcd_out.
- SCAN_DIV = 1: index advances every cycle.

## Test plan
- Reset: assert rst_n = 0 mid-run. Required: busy 0, bcd_out 000, digit_sel 001, seg_out 3F immediately (asynchronous), stable until release.
- value_in = 255 strobed at edge N. Required: bcd_out = 255 (0x255) and bcd_valid pulse at N+8. Scan with SCAN_DIV = 4 shows seg 6D/6D/5B on digit_sel 001/010/100.
- value_in = 0. Required: bcd_out 000; seg_out 3F on ones; seg_out 00 on tens and hundreds.
- value_in = 105. Required: bcd_out 0x105; tens shows 3F (not blanked); hundreds 06; ones 6D.
- Strobe 7 at edge N, then strobe 42 and 99 at N+3 and N+5. Required: bcd_out 0x007 at N+8; 99 starts at N+9; bcd_out 0x099 at N+17; 42 is never displayed.
- Strobe 200, then pull rst_n low at N+4 and release. Required: bcd_out stays 000, no bcd_valid pulse. A fresh strobe of 13 yields 0x013 after 8 cycles.
